// File: rtl/lvds_tx_pkg.sv
// Shared types and constants for the LVDS TX link controller.
package lvds_tx_pkg;

    typedef enum logic [2:0] {
        INIT,
        TRAIN,
        ALIGN,
        DONE,
        FAIL
    } state_e;

    localparam logic [7:0] TRAIN_WORD = 8'hF0;
    localparam logic [7:0] SYNC_WORD  = 8'hBC;
    localparam logic [7:0] IDLE_WORD  = 8'hC5;

    // x^7 + x^6 + 1: feedback from the two oldest state bits
    localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;
    localparam logic [6:0] PRBS7_SEED = 7'h01;

endpackage

// File: rtl/lvds_tx_ack_filt.sv
// Sideband ack qualifier: 2-FF synchronizer followed by a run-length filter
// that flips ack only after ACK_FILT consecutive opposite samples.
module lvds_tx_ack_filt #(
    parameter int unsigned ACK_FILT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sin_i,
    output logic ack_o
);

    localparam int unsigned CNT_W = $clog2(ACK_FILT);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_q, ack_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            ack_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], sin_i};
            cnt_q  <= cnt_d;
            ack_q  <= ack_d;
        end
    end

    // Count samples disagreeing with ack; any agreeing sample restarts the run
    always_comb begin
        cnt_d = '0;
        ack_d = ack_q;
        if (sync_q[1] != ack_q) begin
            if (cnt_q == CNT_W'(ACK_FILT - 1)) begin
                ack_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign ack_o = ack_q;

endmodule

// File: rtl/lvds_tx_link_ctrl.sv
// Multi-lane LVDS TX link controller: bring-up, data/idle streaming, retry and loss handling.
// Optional per-lane PRBS7 test stream when LVDS_TX_PRBS_EN is defined.
module lvds_tx_link_ctrl
    import lvds_tx_pkg::*;
#(
    parameter int unsigned LANES     = 16,
    parameter int unsigned LANE_W    = 8,
    parameter int unsigned P_TIMEOUT = 'h98968,
    parameter int unsigned RETRY_MAX = 3,
    parameter int unsigned ACK_FILT  = 16,
    parameter int unsigned GAP_CYC   = 256,
    parameter int unsigned SYNC_LEN  = 4
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic                           RESTART,
    input  logic [LANES*LANE_W-1:0]        TX_DATA,
    input  logic                           TX_VALID,
    output logic                           TX_READY,
    input  logic                           PRBS_MODE,
    output logic [LANES*LANE_W-1:0]        SER_DATA,
    output logic                           LVDS_TX_SOUT,
    input  logic                           LVDS_TX_SIN,
    output logic                           LVDS_INIT_DONE,
    output logic                           LINK_FAIL,
    output logic                           LINK_LOST,
    output logic [$clog2(RETRY_MAX+1)-1:0] RETRY_CNT
);

    localparam int unsigned DW      = LANES * LANE_W;
    localparam int unsigned RC_W    = $clog2(RETRY_MAX + 1);
    localparam int unsigned TMR_M0  = (P_TIMEOUT > GAP_CYC) ? P_TIMEOUT : GAP_CYC;
    localparam int unsigned TMR_MAX = (TMR_M0 > SYNC_LEN) ? TMR_M0 : SYNC_LEN;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX);
    localparam int unsigned WREP    = LANE_W / 8 + 1;

    // Replicate/truncate an 8-bit pattern to one lane, then across all lanes
    function automatic logic [DW-1:0] rep_word(input logic [7:0] w);
        logic [8*WREP-1:0] ext;
        ext = {WREP{w}};
        return {LANES{ext[LANE_W-1:0]}};
    endfunction

    localparam logic [DW-1:0] TRAIN_BUS = rep_word(TRAIN_WORD);
    localparam logic [DW-1:0] SYNC_BUS  = rep_word(SYNC_WORD);
    localparam logic [DW-1:0] IDLE_BUS  = rep_word(IDLE_WORD);

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [RC_W-1:0]  retry_q, retry_d;
    logic [DW-1:0]    ser_q, ser_d;
    logic             sout_q, done_q, fail_q, lost_q, lost_d;
    logic             ack;
    logic [DW-1:0]    prbs_word_c;

    lvds_tx_ack_filt #(.ACK_FILT(ACK_FILT)) u_ack_filt (
        .clk   (CLK),
        .rst_n (RST_N),
        .sin_i (LVDS_TX_SIN),
        .ack_o (ack)
    );

`ifdef LVDS_TX_PRBS_EN
    function automatic logic [6:0] seed_rot(input int i);
        logic [13:0] t;
        t = {PRBS7_SEED, PRBS7_SEED} << (i % 7);
        return t[13:7];
    endfunction

    // Advance one LFSR by LANE_W bits; returns {next_state, bits}, first bit in LSB
    function automatic logic [LANE_W+6:0] prbs_adv(input logic [6:0] seed);
        logic [6:0]        s;
        logic [LANE_W-1:0] bits;
        logic              fb;
        s    = seed;
        bits = '0;
        for (int unsigned b = 0; b < LANE_W; b++) begin
            fb   = ^(s & PRBS7_TAPS);
            s    = {s[5:0], fb};
            bits = {fb, bits[LANE_W-1:1]};
        end
        return {s, bits};
    endfunction

    logic done_entry_c;
    assign done_entry_c = (state_d == DONE) && (state_q != DONE);
    assign TX_READY     = (state_q == DONE) && !PRBS_MODE;

    for (genvar l = 0; l < LANES; l++) begin : g_prbs
        logic [6:0]        lfsr_q;
        logic [LANE_W+6:0] adv_c;

        assign adv_c = prbs_adv(lfsr_q);
        assign prbs_word_c[l*LANE_W +: LANE_W] = adv_c[LANE_W-1:0];

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                lfsr_q <= seed_rot(l);
            end else if (done_entry_c) begin
                lfsr_q <= seed_rot(l);
            end else if (state_q == DONE && PRBS_MODE) begin
                lfsr_q <= adv_c[LANE_W+6:LANE_W];
            end
        end
    end
`else
    logic unused_prbs_mode;
    assign unused_prbs_mode = PRBS_MODE;
    assign prbs_word_c      = IDLE_BUS;
    assign TX_READY         = (state_q == DONE);
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= INIT;
            timer_q <= '0;
            retry_q <= '0;
            ser_q   <= IDLE_BUS;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            ser_q   <= ser_d;
            sout_q  <= (state_d == TRAIN) || (state_d == ALIGN);
            done_q  <= (state_d == DONE);
            fail_q  <= (state_d == FAIL);
            lost_q  <= lost_d;
        end
    end

    // Next state, retry bookkeeping and the word loaded into SER_DATA
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        lost_d  = 1'b0;
        ser_d   = IDLE_BUS;

        case (state_q)
            INIT: begin
                if (timer_q == TMR_W'(GAP_CYC - 1)) state_d = TRAIN;
            end
            TRAIN: begin
                if (ack) begin
                    state_d = ALIGN;
                end else if (timer_q == TMR_W'(P_TIMEOUT - 1)) begin
                    retry_d = retry_q + RC_W'(1);
                    state_d = (retry_d == RC_W'(RETRY_MAX)) ? FAIL : INIT;
                end
            end
            ALIGN: begin
                if (!ack) begin
                    state_d = INIT;
                end else if (timer_q == TMR_W'(SYNC_LEN - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!ack) begin
                    state_d = INIT;
                    retry_d = '0;
                    lost_d  = 1'b1;
                end
            end
            FAIL: begin
                if (RESTART) begin
                    state_d = INIT;
                    retry_d = '0;
                end
            end
            default: state_d = INIT;
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q != '1) begin
            timer_d = timer_q + TMR_W'(1);
        end else begin
            timer_d = timer_q;
        end

        case (state_d)
            TRAIN:   ser_d = TRAIN_BUS;
            ALIGN:   ser_d = SYNC_BUS;
            default: ser_d = IDLE_BUS;
        endcase
`ifdef LVDS_TX_PRBS_EN
        if (state_q == DONE && PRBS_MODE) ser_d = prbs_word_c;
`endif
        if (TX_READY && TX_VALID) ser_d = TX_DATA;
    end

    assign SER_DATA       = ser_q;
    assign LVDS_TX_SOUT   = sout_q;
    assign LVDS_INIT_DONE = done_q;
    assign LINK_FAIL      = fail_q;
    assign LINK_LOST      = lost_q;
    assign RETRY_CNT      = retry_q;

endmodule
